// File: rtl/sdram_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_cmd_arbiter_if
//  Description : Command / data bus between the SDRAM command arbiter and
//                the 16-bit SDRAM controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface sdram_cmd_arbiter_if;
    logic [1:0]  sdr_cmd;       // 00 nop, 01 wr 256 B, 10 rd 32 B, 11 rd 256 B
    logic [22:0] sdr_addr;      // controller word address
    logic [1:0]  sdr_cmd_ack;   // controller command acknowledge
    logic        sdr_rd_valid;  // read data valid
    logic        sdr_wr_valid;  // controller consuming write data
    logic [15:0] sdr_dout;      // read data from controller

    // Arbiter side
    modport master (
        output sdr_cmd,
        output sdr_addr,
        input  sdr_cmd_ack,
        input  sdr_rd_valid,
        input  sdr_wr_valid,
        input  sdr_dout
    );

    // Controller side
    modport slave (
        input  sdr_cmd,
        input  sdr_addr,
        output sdr_cmd_ack,
        output sdr_rd_valid,
        output sdr_wr_valid,
        output sdr_dout
    );
endinterface
`default_nettype wire

// File: rtl/sdram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_cmd_arbiter
//  Description : Three-way SDRAM command arbiter (video refill > cache
//                write-back > cache line fill), video fetch address counter
//                with frame wrap, and read-data steering to the video queue
//                (2x16 packed to 32 bits) or to the cache fill/drain strobes.
//  Option      : SDRAM_ARB_STATS_EN - saturating 16-bit command counters on
//                stat_vid_o / stat_cache_o (tied to 0 when undefined).
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_cmd_arbiter #(
    parameter int VID_WORDS  = 19200,
    parameter int VID_ADDR_W = 19
) (
    input  logic                  clk,
    input  logic                  reset_i,
    sdram_cmd_arbiter_if.master   sdr,
    input  logic                  video_en_i,
    input  logic                  vq_almost_empty_i,
    input  logic                  cache_wr_req_i,
    input  logic                  cache_rd_req_i,
    input  logic [17:0]           cache_waddr_i,
    input  logic [16:0]           cache_raddr_i,
    output logic [31:0]           vq_data_o,
    output logic                  vq_wr_o,
    output logic                  cache_fill_we_o,
    output logic                  cache_drain_re_o,
    output logic [VID_ADDR_W-1:0] vid_addr_o,
    output logic                  frame_wrap_o,
    output logic [15:0]           stat_vid_o,
    output logic [15:0]           stat_cache_o
);

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WR256 = 2'b01;
    localparam logic [1:0] CMD_RD32  = 2'b10;
    localparam logic [1:0] CMD_RD256 = 2'b11;

    localparam logic [VID_ADDR_W-1:0] VID_LAST = VID_ADDR_W'(VID_WORDS - 1);

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_VIDEO = 2'd1,
        OWN_CACHE = 2'd2
    } owner_t;

    logic [1:0]            cmd_q,      cmd_d;
    logic [VID_ADDR_W-1:0] vid_addr_q, vid_addr_d;
    owner_t                owner_q;
    logic                  ack_idle_q;
    logic                  phase_q;
    logic [15:0]           low_q;
    logic [31:0]           vq_data_q;
    logic                  vq_wr_q;
    logic                  frame_wrap_q;
    logic [22:0]           sdr_addr_w;

    logic                  ack_accept_w;
    logic                  vid_ack_w;
    logic                  cache_ack_w;

    // Bit 17 of the write-back address is outside the SDRAM window.
    logic                  unused_waddr_w;
    assign unused_waddr_w = cache_waddr_i[17];

    // An ack counts only on its first cycle after an idle ack bus.
    assign ack_accept_w = ack_idle_q & (sdr.sdr_cmd_ack != 2'b00);
    assign vid_ack_w    = ack_accept_w & (sdr.sdr_cmd_ack == CMD_RD32);
    assign cache_ack_w  = ack_accept_w & sdr.sdr_cmd_ack[0];

    // Fixed-priority request selection, re-evaluated every cycle.
    always_comb begin
        cmd_d = CMD_NOP;
        if (video_en_i && vq_almost_empty_i) begin
            cmd_d = CMD_RD32;
        end else if (cache_wr_req_i) begin
            cmd_d = CMD_WR256;
        end else if (cache_rd_req_i) begin
            cmd_d = CMD_RD256;
        end
    end

    // Video burst address advances once per accepted video ack, wrapping per frame.
    always_comb begin
        vid_addr_d = vid_addr_q;
        if (vid_ack_w) begin
            vid_addr_d = (vid_addr_q == VID_LAST) ? '0 : vid_addr_q + VID_ADDR_W'(1);
        end
    end

    // Controller address follows the registered command.
    always_comb begin
        sdr_addr_w = '0;
        case (cmd_q)
            CMD_WR256: sdr_addr_w = {cache_waddr_i[16:0], 6'b000000};
            CMD_RD32:  sdr_addr_w = 23'({1'b1, vid_addr_q, 3'b000});
            CMD_RD256: sdr_addr_w = {cache_raddr_i, 6'b000000};
            default:   sdr_addr_w = '0;
        endcase
    end

    // Command register, bus ownership, video address and video word packing.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            cmd_q        <= CMD_NOP;
            owner_q      <= OWN_IDLE;
            ack_idle_q   <= 1'b0;
            vid_addr_q   <= '0;
            phase_q      <= 1'b0;
            low_q        <= '0;
            vq_data_q    <= '0;
            vq_wr_q      <= 1'b0;
            frame_wrap_q <= 1'b0;
        end else begin
            cmd_q        <= cmd_d;
            ack_idle_q   <= (sdr.sdr_cmd_ack == 2'b00);
            vid_addr_q   <= vid_addr_d;
            frame_wrap_q <= vid_ack_w & (vid_addr_q == VID_LAST);
            vq_wr_q      <= 1'b0;

            if (owner_q == OWN_VIDEO && sdr.sdr_rd_valid) begin
                if (!phase_q) begin
                    low_q   <= sdr.sdr_dout;
                    phase_q <= 1'b1;
                end else begin
                    vq_data_q <= {sdr.sdr_dout, low_q};
                    vq_wr_q   <= 1'b1;
                    phase_q   <= 1'b0;
                end
            end

            // A new video burst always starts on a low half; placed last so it wins.
            if (vid_ack_w) begin
                owner_q <= OWN_VIDEO;
                phase_q <= 1'b0;
            end else if (cache_ack_w) begin
                owner_q <= OWN_CACHE;
            end
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] stat_vid_q;
    logic [15:0] stat_cache_q;

    // Saturating counters of accepted video and cache commands.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            stat_vid_q   <= '0;
            stat_cache_q <= '0;
        end else begin
            if (vid_ack_w && stat_vid_q != 16'hFFFF) begin
                stat_vid_q <= stat_vid_q + 16'd1;
            end
            if (cache_ack_w && stat_cache_q != 16'hFFFF) begin
                stat_cache_q <= stat_cache_q + 16'd1;
            end
        end
    end

    assign stat_vid_o   = stat_vid_q;
    assign stat_cache_o = stat_cache_q;
`else
    assign stat_vid_o   = '0;
    assign stat_cache_o = '0;
`endif

    assign sdr.sdr_cmd       = cmd_q;
    assign sdr.sdr_addr      = sdr_addr_w;
    assign vq_data_o         = vq_data_q;
    assign vq_wr_o           = vq_wr_q;
    assign vid_addr_o        = vid_addr_q;
    assign frame_wrap_o      = frame_wrap_q;
    assign cache_fill_we_o   = (owner_q == OWN_CACHE) & sdr.sdr_rd_valid;
    assign cache_drain_re_o  = (owner_q == OWN_CACHE) & sdr.sdr_wr_valid;

endmodule
`default_nettype wire

// File: tb/tb_sdram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_cmd_arbiter
//  Description : Randomized scoreboard bench for sdram_cmd_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdram_cmd_arbiter;
    localparam int VID_WORDS  = 19200;
    localparam int VID_ADDR_W = 19;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_i = 1'b1;
    logic                  video_en_i = 1'b0;
    logic                  vq_ae = 1'b0;
    logic                  wr_req = 1'b0;
    logic                  rd_req = 1'b0;
    logic [17:0]           waddr = '0;
    logic [16:0]           raddr = '0;
    logic [31:0]           vq_data_o;
    logic                  vq_wr_o;
    logic                  cache_fill_we_o;
    logic                  cache_drain_re_o;
    logic [VID_ADDR_W-1:0] vid_addr_o;
    logic                  frame_wrap_o;
    logic [15:0]           stat_vid_o;
    logic [15:0]           stat_cache_o;

    sdram_cmd_arbiter_if sdr_bus ();

    sdram_cmd_arbiter #(.VID_WORDS(VID_WORDS), .VID_ADDR_W(VID_ADDR_W)) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .sdr               (sdr_bus),
        .video_en_i        (video_en_i),
        .vq_almost_empty_i (vq_ae),
        .cache_wr_req_i    (wr_req),
        .cache_rd_req_i    (rd_req),
        .cache_waddr_i     (waddr),
        .cache_raddr_i     (raddr),
        .vq_data_o         (vq_data_o),
        .vq_wr_o           (vq_wr_o),
        .cache_fill_we_o   (cache_fill_we_o),
        .cache_drain_re_o  (cache_drain_re_o),
        .vid_addr_o        (vid_addr_o),
        .frame_wrap_o      (frame_wrap_o),
        .stat_vid_o        (stat_vid_o),
        .stat_cache_o      (stat_cache_o)
    );

    // Counters and reference model state
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_vq[$];     // scoreboard of expected queue words
    logic [15:0] halves[$];     // words of the current video pair
    int m_owner = 0;            // 0 none, 1 video, 2 cache
    int m_vid_acks = 0;         // video acks since reset
    int m_stat_vid = 0;
    int m_stat_cache = 0;
    int exp_fill = 0, exp_drain = 0, exp_wrap = 0, exp_vq_total = 0;
    int act_fill = 0, act_drain = 0, act_wrap = 0, act_vq = 0;
    logic [31:0] mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops the scoreboard on every queue write and counts strobes.
    always @(negedge clk) begin
        if (cache_fill_we_o)  act_fill++;
        if (cache_drain_re_o) act_drain++;
        if (frame_wrap_o)     act_wrap++;
        if (vq_wr_o) begin
            act_vq++;
            if (exp_vq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL vq_unexpected actual=0x%0h required=no_write", vq_data_o);
            end else begin
                mon_exp = exp_vq.pop_front();
                chk("vq_data", 64'(vq_data_o), 64'(mon_exp));
            end
        end
    end

    function automatic logic [22:0] exp_addr(input logic [1:0] c);
        logic [VID_ADDR_W-1:0] va;
        va = VID_ADDR_W'(m_vid_acks % VID_WORDS);
        case (c)
            2'b01:   return {waddr[16:0], 6'd0};
            2'b10:   return 23'(4194304 + 8 * int'(va));
            2'b11:   return {raddr, 6'd0};
            default: return 23'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_cmd();
        if (video_en_i && vq_ae) return 2'b10;
        if (wr_req)              return 2'b01;
        if (rd_req)              return 2'b11;
        return 2'b00;
    endfunction

    task automatic do_reset();
        reset_i = 1'b1;
        video_en_i = 0; vq_ae = 0; wr_req = 0; rd_req = 0;
        sdr_bus.sdr_cmd_ack = 2'b00;
        sdr_bus.sdr_rd_valid = 0;
        sdr_bus.sdr_wr_valid = 0;
        sdr_bus.sdr_dout = '0;
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        m_owner = 0;
        m_vid_acks = 0;
        halves.delete();
        m_stat_vid = 0;
        m_stat_cache = 0;
    endtask

    task automatic do_ack(input logic [1:0] code, input int hold);
        sdr_bus.sdr_cmd_ack = code;
        repeat (hold) tick();
        sdr_bus.sdr_cmd_ack = 2'b00;
        tick();
        if (code == 2'b10) begin
            m_vid_acks++;
            if (m_vid_acks % VID_WORDS == 0) exp_wrap++;
            m_owner = 1;
            halves.delete();
            if (m_stat_vid < 65535) m_stat_vid++;
        end else begin
            m_owner = 2;
            if (m_stat_cache < 65535) m_stat_cache++;
        end
    endtask

    task automatic send_rd(input int n, input logic [15:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = rnd ? 16'($urandom) : base + 16'(i);
            if (rnd && $urandom_range(0, 3) == 0) begin
                sdr_bus.sdr_rd_valid = 0;
                tick();
            end
            sdr_bus.sdr_rd_valid = 1;
            sdr_bus.sdr_dout = w;
            if (m_owner == 1) begin
                halves.push_back(w);
                if (halves.size() == 2) begin
                    exp_vq.push_back({halves[1], halves[0]});
                    exp_vq_total++;
                    halves.delete();
                end
            end else if (m_owner == 2) begin
                exp_fill++;
            end
            tick();
        end
        sdr_bus.sdr_rd_valid = 0;
        tick();
        tick();
    endtask

    task automatic send_wr(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                sdr_bus.sdr_wr_valid = 0;
                tick();
            end
            sdr_bus.sdr_wr_valid = 1;
            if (m_owner == 2) exp_drain++;
            tick();
        end
        sdr_bus.sdr_wr_valid = 0;
        tick();
    endtask

    task automatic check_cmd(input string name);
        tick();
        chk({name, "_cmd"}, 64'(sdr_bus.sdr_cmd), 64'(exp_cmd()));
        chk({name, "_addr"}, 64'(sdr_bus.sdr_addr), 64'(exp_addr(exp_cmd())));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vq_before, fill_before;
        do_reset();

        // Reset state; idle owner ignores data strobes
        chk("rst_cmd", 64'(sdr_bus.sdr_cmd), 64'd0);
        chk("rst_addr", 64'(sdr_bus.sdr_addr), 64'd0);
        chk("rst_vid_addr", 64'(vid_addr_o), 64'd0);
        chk("rst_vq_wr", 64'(vq_wr_o), 64'd0);
        chk("rst_vq_data", 64'(vq_data_o), 64'd0);
        chk("rst_wrap", 64'(frame_wrap_o), 64'd0);
        chk("rst_stat_vid", 64'(stat_vid_o), 64'd0);
        chk("rst_stat_cache", 64'(stat_cache_o), 64'd0);
        sdr_bus.sdr_rd_valid = 1;
        sdr_bus.sdr_wr_valid = 1;
        #1;
        chk("idle_fill", 64'(cache_fill_we_o), 64'd0);
        chk("idle_drain", 64'(cache_drain_re_o), 64'd0);
        sdr_bus.sdr_rd_valid = 0;
        sdr_bus.sdr_wr_valid = 0;
        tick();

        // Directed priority sequence
        waddr = 18'($urandom);
        raddr = 17'($urandom);
        video_en_i = 1; vq_ae = 1; wr_req = 1; rd_req = 1;
        tick();
        chk("prio_vid_cmd", 64'(sdr_bus.sdr_cmd), 64'd2);
        chk("prio_vid_addr", 64'(sdr_bus.sdr_addr), 64'h400000);
        vq_ae = 0;
        check_cmd("prio_wr");
        wr_req = 0;
        check_cmd("prio_rd");

        // Randomized request patterns
        for (int i = 0; i < 24; i++) begin
            video_en_i = 1'($urandom); vq_ae = 1'($urandom);
            wr_req = 1'($urandom);     rd_req = 1'($urandom);
            waddr = 18'($urandom);     raddr = 17'($urandom);
            check_cmd("rand_prio");
        end
        video_en_i = 0; vq_ae = 0; wr_req = 0; rd_req = 0;
        tick();

        // Video packing with an incrementing pattern
        vq_before = act_vq;
        do_ack(2'b10, 1);
        send_rd(16, 16'h0001, 1'b0);
        chk("pack_writes", 64'(act_vq - vq_before), 64'd8);
        chk("pack_vid_addr", 64'(vid_addr_o), 64'd1);

        // Random video bursts with gaps and varying ack lengths
        for (int b = 0; b < 3; b++) begin
            do_ack(2'b10, $urandom_range(1, 3));
            send_rd(16, 16'h0, 1'b1);
            chk("burst_vid_addr", 64'(vid_addr_o), 64'(m_vid_acks % VID_WORDS));
        end

        // Cache fill then drain
        vq_before = act_vq;
        do_ack(2'b11, $urandom_range(1, 3));
        send_rd(128, 16'h0, 1'b1);
        chk("fill_count", 64'(act_fill), 64'(exp_fill));
        chk("fill_no_vq", 64'(act_vq - vq_before), 64'd0);
        do_ack(2'b01, $urandom_range(1, 3));
        send_wr(128);
        chk("drain_count", 64'(act_drain), 64'(exp_drain));

        // Held video ack counts once; write strobes ignored while video owns
        do_ack(2'b10, 3);
        chk("held_ack_vid_addr", 64'(vid_addr_o), 64'(m_vid_acks % VID_WORDS));
        send_wr(4);
        chk("video_no_drain", 64'(act_drain), 64'(exp_drain));

        // Reset part-way through a burst discards the rest
        send_rd(5, 16'h0, 1'b1);
        do_reset();
        vq_before = act_vq;
        fill_before = act_fill;
        send_rd(11, 16'h0, 1'b1);
        chk("rst_burst_no_vq", 64'(act_vq - vq_before), 64'd0);
        chk("rst_burst_no_fill", 64'(act_fill - fill_before), 64'd0);
        chk("rst_burst_queue", 64'(exp_vq.size()), 64'd0);

        // Command statistics
        do_ack(2'b10, 1);
        do_ack(2'b10, 2);
        do_ack(2'b10, 1);
        do_ack(2'b01, 2);
        do_ack(2'b11, 1);
`ifdef SDRAM_ARB_STATS_EN
        chk("stat_vid", 64'(stat_vid_o), 64'(m_stat_vid));
        chk("stat_cache", 64'(stat_cache_o), 64'(m_stat_cache));
`else
        chk("stat_vid", 64'(stat_vid_o), 64'd0);
        chk("stat_cache", 64'(stat_cache_o), 64'd0);
`endif

        // Frame wrap
        do_reset();
        for (int i = 0; i < VID_WORDS - 1; i++) do_ack(2'b10, 1);
        chk("pre_wrap_vid_addr", 64'(vid_addr_o), 64'(VID_WORDS - 1));
        chk("pre_wrap_pulses", 64'(act_wrap), 64'(exp_wrap));
        do_ack(2'b10, 1);
        chk("wrap_vid_addr", 64'(vid_addr_o), 64'd0);
        chk("wrap_pulses", 64'(act_wrap), 64'(exp_wrap));
        chk("wrap_pulse_ended", 64'(frame_wrap_o), 64'd0);
        video_en_i = 1; vq_ae = 1;
        tick();
        chk("wrap_cmd", 64'(sdr_bus.sdr_cmd), 64'd2);
        chk("wrap_addr", 64'(sdr_bus.sdr_addr), 64'h400000);
        video_en_i = 0; vq_ae = 0;
        tick();
        tick();

        chk("final_queue_empty", 64'(exp_vq.size()), 64'd0);
        chk("final_vq_total", 64'(act_vq), 64'(exp_vq_total));
        chk("final_fill_total", 64'(act_fill), 64'(exp_fill));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Command arbiter and read-data steering stage sitting directly upstream of the 16-bit SDRAM controller, in the SDRAM clock domain.
- Selects between three requesters each cycle: video refill (highest priority), cache write-back, and cache line fill.
- Drives the controller's command and address.
- Owns the video fetch address counter with frame wrap.
- Routes returned SDRAM words either to the video queue (packed 2×16 into 32 bits) or to the cache as fill/drain strobes.

Parameters:
- VID_WORDS, 19200: number of 32-byte video bursts per frame; the video address wraps after VID_WORDS-1.
- VID_ADDR_W, 19: width of the video burst address.

Ports:
- clk  in  1  SDRAM-domain clock
- reset_i  in  1  synchronous reset, active high
- video_en_i  in  1  video refill enable (system out of reset)
- vq_almost_empty_i  in  1  video queue below its almost-empty threshold
- cache_wr_req_i  in  1  cache requests a 256-byte write-back
- cache_rd_req_i  in  1  cache requests a 256-byte line fill
- cache_waddr_i  in  18  write-back line address; bits [16:0] are used
- cache_raddr_i  in  17  fill line address (CPU address bits [24:8])
- sdr_cmd_o  out  2  00 nop, 01 write 256 B, 10 read 32 B, 11 read 256 B
- sdr_addr_o  out  23  controller word address
- sdr_cmd_ack_i  in  2  controller command acknowledge
- sdr_rd_valid_i  in  1  read data valid
- sdr_wr_valid_i  in  1  controller consuming write data
- sdr_dout_i  in  16  read data from controller
- vq_data_o  out  32  packed video word
- vq_wr_o  out  1  video queue write strobe
- cache_fill_we_o  out  1  write sdr_dout_i into the cache
- cache_drain_re_o  out  1  advance the cache write-back data
- vid_addr_o  out  VID_ADDR_W  current video burst address
- frame_wrap_o  out  1  one-cycle pulse when vid_addr wraps to 0
- stat_vid_o  out  16  video command count (optional feature)
- stat_cache_o  out  16  cache command count (optional feature)

Behaviour:

Reset values (reset_i synchronous, all sequential state):
- sdr_cmd_o=00, owner=IDLE, vid_addr=0, phase=0.
- vq_wr_o=0, vq_data_o=0, frame_wrap_o=0, stat counters 0.
- Reset asserted mid-burst discards the remaining burst data: owner returns to IDLE and no strobes are issued.

Command selection (registered, re-evaluated every cycle):
- video_en_i & vq_almost_empty_i → 10
- else cache_wr_req_i → 01
- else cache_rd_req_i → 11
- else 00
- Requesters hold their request until the controller acknowledges; the arbiter itself does not latch requests.
- When requests are simultaneous, the higher priority wins.

Address (combinational from the registered sdr_cmd_o):
- 01 → {cache_waddr_i[16:0], 6'b0}
- 10 → {1'b1, vid_addr, 3'b0}
- 11 → {cache_raddr_i, 6'b0}
- 00 → 0

Acknowledge detection:
- Register ack_idle = (sdr_cmd_ack_i == 00).
- An ack is accepted only in a cycle where ack_idle=1 and sdr_cmd_ack_i != 00, so a multi-cycle ack counts once.
- Ack 10: owner ← VIDEO, phase ← 0, and vid_addr ← (vid_addr == VID_WORDS-1) ? 0 : vid_addr+1. frame_wrap_o pulses in the cycle after the wrap.
- Ack 01 or 11: owner ← CACHE.

Data steering:
- owner=VIDEO & sdr_rd_valid_i, phase 0: latch the word as the low half, phase ← 1.
- owner=VIDEO & sdr_rd_valid_i, phase 1: registered output next cycle, vq_data_o = {sdr_dout_i, low}, vq_wr_o=1 for one cycle, phase ← 0.
- A 32-byte burst (16 words) therefore yields exactly 8 queue writes.
- cache_fill_we_o = (owner==CACHE) & sdr_rd_valid_i, combinational with zero latency.
- cache_drain_re_o = (owner==CACHE) & sdr_wr_valid_i, combinational with zero latency.
- When owner=IDLE, sdr_rd_valid_i and sdr_wr_valid_i are ignored.

video_en_i low:
- No video commands are issued; vid_addr holds its value.
- A video burst already in flight completes normally.

Optional Feature:
- Macro: SDRAM_ARB_STATS_EN.
- Defined: stat_vid_o and stat_cache_o are 16-bit saturating counters (stop at 16'hFFFF), incremented once per accepted video ack and per accepted cache ack respectively, and cleared by reset_i.
- Not defined: both ports are constant 0 and no counter logic is synthesised.

Test Plan:
- Priority: reset, then video_en_i=1 with vq_almost_empty_i, cache_wr_req_i and cache_rd_req_i all 1 → sdr_cmd_o=10 and sdr_addr_o=23'h400000. Drop almost_empty → 01 with address {waddr[16:0],6'b0}. Drop wr_req → 11.
- Video packing: ack 10, then 16 valid words 0x0001..0x0010 → 8 vq_wr_o pulses carrying 0x00020001, 0x00040003, …, 0x0010000F. vid_addr_o=1 afterwards.
- Wrap: preload by issuing 19199 video acks, then one more ack → vid_addr_o=0 and frame_wrap_o high for exactly one cycle. The next video command's address is 23'h400000.
- Cache steering: ack 11, then 128 valid words → 128 cache_fill_we_o pulses and 0 vq_wr_o pulses. Ack 01 with 128 sdr_wr_valid_i → 128 cache_drain_re_o pulses.
- Held ack and reset: sdr_cmd_ack_i=10 held for 3 cycles → vid_addr increments by exactly 1. reset_i asserted after 5 of 16 video words → no further vq_wr_o, and subsequent valid words are ignored.
- With SDRAM_ARB_STATS_EN: 3 video acks and 2 cache acks → stat_vid_o=3, stat_cache_o=2. Without the macro, both read 0.
